// File: rtl/mpu_det_ctrl.sv
// -----------------------------------------------------------------------------
// mpu_det_ctrl
//
// Sequential "diagonal-product" determinant engine for square matrices of
// order 1..MAX_SIZE (fixed at 5). Elements are streamed in row-major order,
// stored locally, then every diagonal term is formed one row per cycle on a
// single shared 16x8 multiplier. Main terms are added to the accumulator and
// secondary terms are subtracted, all modulo 2^16.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a new determinant (honoured only in IDLE)
//   size[7:0]    matrix order n, sampled with start (legal 1..5)
//   in_valid     element stream valid
//   in_data[7:0] unsigned element value, row-major
//   in_ready     element accepted on in_valid & in_ready (LOAD only)
//   det_valid    result valid (DONE)
//   det_ready    result consumed on det_valid & det_ready
//   determinant  16-bit result, held after hand-off until next result
//   busy         high in every state except IDLE
//   err          one-cycle pulse after a start with an illegal size
// -----------------------------------------------------------------------------
module mpu_det_ctrl #(
    parameter int MAX_SIZE = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  size,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        det_valid,
    input  logic        det_ready,
    output logic [15:0] determinant,
    output logic        busy,
    output logic        err
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int NELEM  = MAX_SIZE * MAX_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          n_q, n_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          term_q, term_d;
    logic                sec_q, sec_d;
    logic [ACC_W-1:0]    part_q, part_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    det_q, det_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   m_q [NELEM];

    // Truncating 16x8 multiply; only the low 16 bits of the product survive.
    function automatic logic [ACC_W-1:0] mul_trunc(input logic [ACC_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [ACC_W+DATA_W-1:0] full;
        full = {{DATA_W{1'b0}}, a} * {{ACC_W{1'b0}}, b};
        return full[ACC_W-1:0];
    endfunction

    logic             size_ok;
    logic             load_fire;
    logic [4:0]       last_elem;
    logic [2:0]       last_k;
    logic             last_row;
    logic [3:0]       col_main;
    logic [3:0]       col_sec;
    logic [3:0]       col_raw;
    logic [3:0]       col;
    logic [4:0]       idx;
    logic [DATA_W-1:0] elem;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_upd;

    assign size_ok   = (size >= 8'd1) && (size <= 8'(MAX_SIZE));
    assign load_fire = (state_q == LOAD) && in_valid;
    assign last_elem = 5'(n_q) * 5'(n_q) - 5'd1;

    // Orders 1 and 2 have a single main (and for n=2 a single secondary)
    // term; from order 3 on there are n of each.
    assign last_k   = (n_q >= 3'd3) ? (n_q - 3'd1) : 3'd0;
    assign last_row = (row_q == (n_q - 3'd1));

    // Column selection. Main: (r+k) mod n, with r+k < 2n.
    // Secondary: (n-1-k-r) mod n, evaluated as (2n-1-k-r) which stays in
    // 1..2n-1, so a single conditional subtract of n reduces it.
    assign col_main = {1'b0, row_q} + {1'b0, term_q};
    assign col_sec  = {n_q, 1'b0} - 4'd1 - {1'b0, term_q} - {1'b0, row_q};
    assign col_raw  = sec_q ? col_sec : col_main;
    assign col      = (col_raw >= {1'b0, n_q}) ? (col_raw - {1'b0, n_q}) : col_raw;
    assign idx      = 5'(row_q) * 5'(n_q) + 5'(col);
    assign elem     = m_q[idx];

    // Row 0 seeds the partial product; later rows multiply into it.
    assign prod    = (row_q == 3'd0) ? {{(ACC_W-DATA_W){1'b0}}, elem}
                                     : mul_trunc(part_q, elem);
    assign acc_upd = sec_q ? (acc_q - prod) : (acc_q + prod);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        term_d  = term_q;
        sec_d   = sec_q;
        part_d  = part_q;
        acc_d   = acc_q;
        det_d   = det_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        n_d     = size[2:0];
                        cnt_d   = 5'd0;
                        acc_d   = '0;
                        row_d   = 3'd0;
                        term_d  = 3'd0;
                        sec_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == last_elem) begin
                        cnt_d   = 5'd0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            CALC: begin
                part_d = prod;
                if (last_row) begin
                    row_d = 3'd0;
                    acc_d = acc_upd;
                    if (term_q == last_k) begin
                        term_d = 3'd0;
                        if (sec_q || (n_q == 3'd1)) begin
                            sec_d   = 1'b0;
                            det_d   = acc_upd;
                            state_d = DONE;
                        end else begin
                            sec_d = 1'b1;
                        end
                    end else begin
                        term_d = term_q + 3'd1;
                    end
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            DONE: begin
                if (det_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 3'd0;
            cnt_q   <= 5'd0;
            row_q   <= 3'd0;
            term_q  <= 3'd0;
            sec_q   <= 1'b0;
            part_q  <= '0;
            acc_q   <= '0;
            det_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            term_q  <= term_d;
            sec_q   <= sec_d;
            part_q  <= part_d;
            acc_q   <= acc_d;
            det_q   <= det_d;
            err_q   <= err_d;
        end
    end

    // Element store: every location used by a computation is rewritten
    // during LOAD first, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            m_q[cnt_q] <= in_data;
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign det_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign determinant = det_q;

endmodule

// File: tb/tb_mpu_det_ctrl.sv
module tb_mpu_det_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  size;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        det_valid;
    logic        det_ready;
    logic [15:0] determinant;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_det;
    logic [7:0]  exp_m [25];

    always #5 clk = ~clk;

    mpu_det_ctrl #(.MAX_SIZE(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size        (size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .det_valid   (det_valid),
        .det_ready   (det_ready),
        .determinant (determinant),
        .busy        (busy),
        .err         (err)
    );

    // Reference: sum of cyclic diagonal products straight from the term rules.
    function automatic int n_main(input int n);
        return (n >= 3) ? n : 1;
    endfunction

    function automatic int n_sec(input int n);
        return (n >= 3) ? n : ((n == 2) ? 1 : 0);
    endfunction

    function automatic logic [15:0] ref_det(input int n);
        int acc, p, c;
        acc = 0;
        for (int k = 0; k < n_main(n); k++) begin
            p = 1;
            for (int r = 0; r < n; r++)
                p = (p * int'(exp_m[r*n + (r+k) % n])) % 65536;
            acc = (acc + p) % 65536;
        end
        for (int k = 0; k < n_sec(n); k++) begin
            p = 1;
            for (int r = 0; r < n; r++) begin
                c = (((n - 1 - k - r) % n) + n) % n;
                p = (p * int'(exp_m[r*n + c])) % 65536;
            end
            acc = (acc - p + 65536) % 65536;
        end
        return 16'(acc);
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; start = 0; size = 0; in_valid = 0; in_data = 0; det_ready = 0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, in_ready, det_valid, err} !== 4'b0000 || determinant !== 16'h0000)
            $display("FAIL reset_state: flags=%b det=%h required flags=0000 det=0000",
                     {busy, in_ready, det_valid, err}, determinant);
        if ({busy, in_ready, det_valid, err} !== 4'b0000 || determinant !== 16'h0000) errors++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, in_ready, det_valid, err} !== 4'b0000 || determinant !== 16'h0000) begin
            errors++;
            $display("FAIL after_release: flags=%b det=%h required flags=0000 det=0000",
                     {busy, in_ready, det_valid, err}, determinant);
        end
        last_det = 16'h0000;
    endtask

    // Full transaction: start, stream n*n elements (optional stalls), count
    // CALC cycles, check result, hold det_ready low, hand off.
    task automatic run_det(input string name, input int n, input int stall_pct,
                           input int ready_delay, input bit poke);
        logic [15:0] exp;
        int exp_cyc, cyc, bad;
        exp     = ref_det(n);
        exp_cyc = (n_main(n) + n_sec(n)) * n;

        @(negedge clk);
        start = 1'b1; size = 8'(n);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, in_ready, det_valid, err} !== 4'b1100) begin
            errors++;
            $display("FAIL %s start_accept: flags=%b required 1100", name,
                     {busy, in_ready, det_valid, err});
        end

        bad = 0;
        for (int i = 0; i < n*n; i++) begin
            while ($urandom_range(99) < stall_pct) begin
                in_valid = 1'b0;
                if (poke) begin start = 1'b1; size = 8'($urandom); end
                @(negedge clk);
                start = 1'b0;
                if (in_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b1) bad++;
            end
            if (in_ready !== 1'b1 || err !== 1'b0) bad++;
            in_valid = 1'b1;
            in_data  = exp_m[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s load_phase: %0d bad cycles required 0", name, bad);
        end

        cyc = 0; bad = 0;
        while (det_valid !== 1'b1 && cyc < 300) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) bad++;
            cyc++;
            if (poke) begin
                start = 1'b1; size = 8'($urandom);
                in_valid = 1'(($urandom)); in_data = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (cyc != exp_cyc || bad != 0) begin
            errors++;
            $display("FAIL %s calc_cycles: got %0d (bad %0d) required %0d", name, cyc, bad, exp_cyc);
        end
        checks++;
        if (det_valid !== 1'b1 || determinant !== exp || err !== 1'b0) begin
            errors++;
            $display("FAIL %s result: det_valid=%b det=%h err=%b required 1 %h 0",
                     name, det_valid, determinant, err, exp);
        end

        bad = 0;
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            if (det_valid !== 1'b1 || determinant !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s hold_stable: %0d unstable cycles required 0", name, bad);
        end

        det_ready = 1'b1;
        if (poke) begin start = 1'b1; size = 8'd2; end
        @(negedge clk);
        det_ready = 1'b0; start = 1'b0;
        checks++;
        if ({busy, in_ready, det_valid} !== 3'b000 || determinant !== exp) begin
            errors++;
            $display("FAIL %s handoff: flags=%b det=%h required 000 %h", name,
                     {busy, in_ready, det_valid}, determinant, exp);
        end
        if (poke) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s start_in_done: busy=%b err=%b required 0 0", name, busy, err);
            end
        end
        last_det = exp;
    endtask

    task automatic test_vectors();
        exp_m[0] = 3; exp_m[1] = 5; exp_m[2] = 2; exp_m[3] = 7;
        run_det("n2_a", 2, 0, 0, 0);
        exp_m[0] = 1; exp_m[1] = 2; exp_m[2] = 3; exp_m[3] = 4;
        run_det("n2_b", 2, 0, 0, 0);
        exp_m[0] = 2; exp_m[1] = 0; exp_m[2] = 1;
        exp_m[3] = 1; exp_m[4] = 3; exp_m[5] = 2;
        exp_m[6] = 1; exp_m[7] = 1; exp_m[8] = 1;
        run_det("n3", 3, 0, 0, 0);
        exp_m[0] = 200;
        run_det("n1", 1, 0, 0, 0);
        for (int i = 0; i < 25; i++) exp_m[i] = 8'd255;
        run_det("n5_ff", 5, 0, 1, 0);
    endtask

    task automatic test_err(input int sz);
        @(negedge clk);
        start = 1'b1; size = 8'(sz); in_valid = 1'b1; in_data = 8'h63;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({err, busy, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL err_pulse_%0d: err/busy/in_ready=%b required 100", sz, {err, busy, in_ready});
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({err, busy, in_ready} !== 3'b000 || determinant !== last_det) begin
            errors++;
            $display("FAIL err_end_%0d: flags=%b det=%h required 000 %h", sz,
                     {err, busy, in_ready}, determinant, last_det);
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 9; i++) exp_m[i] = 8'($urandom_range(1, 255));
        @(negedge clk);
        start = 1'b1; size = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_m[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, det_valid, err} !== 4'b0000 || determinant !== 16'h0000) begin
            errors++;
            $display("FAIL abort_async: flags=%b det=%h required 0000 0000",
                     {busy, in_ready, det_valid, err}, determinant);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, in_ready, det_valid, err} !== 4'b0000 || determinant !== 16'h0000) begin
            errors++;
            $display("FAIL abort_release: flags=%b det=%h required 0000 0000",
                     {busy, in_ready, det_valid, err}, determinant);
        end
        last_det = 16'h0000;
        exp_m[0] = 3; exp_m[1] = 5; exp_m[2] = 2; exp_m[3] = 7;
        run_det("after_abort", 2, 0, 10, 0);
    endtask

    task automatic test_random();
        int n, mode;
        for (int t = 0; t < 14; t++) begin
            n    = $urandom_range(1, 5);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 25; i++)
                exp_m[i] = (mode == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            run_det("random", n, 30, $urandom_range(0, 3), 1);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_err(6);
        test_err(0);
        test_err(255);
        test_reset_abort();
        test_random();
        test_err(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpu_det_ctrl.md
MPU_DET_CTRL -- requirements
Module: mpu_det_ctrl

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 5: maximum matrix order; fixed at 5, other values unsupported.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request a new determinant; sampled only in IDLE.
REQ-005 SHALL have port size  in  8  matrix order n, sampled with start.
REQ-006 SHALL have port in_valid  in  1  element stream valid.
REQ-007 SHALL have port in_data  in  8  element value, unsigned, row-major order.
REQ-008 SHALL have port in_ready  out  1  element accepted when in_valid&in_ready.
REQ-009 SHALL have port det_valid  out  1  determinant result valid.
REQ-010 SHALL have port det_ready  in  1  result consumed when det_valid&det_ready.
REQ-011 SHALL have port determinant  out  16  result, modulo 2^16 (two's complement view).
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port err  out  1  one-cycle pulse on rejected start.

Function
REQ-014 SHALL implement states IDLE, LOAD, CALC, DONE; one multiplier (16b x 8b -> 16b, truncated) shared across all terms.
REQ-015 IDLE: start with 1<=size<=5 -> latch n, clear element counter and accumulator, go LOAD next cycle.
REQ-016 IDLE: start with size 0 or >5 -> err=1 for exactly one cycle, stay IDLE, determinant unchanged.
REQ-017 start outside IDLE SHALL be ignored (no err, no effect).
REQ-018 LOAD: in_ready=1; each handshake stores in_data to m[r][c], r,c advancing row-major; after n*n-th handshake go CALC next cycle.
REQ-019 in_ready SHALL be 0 in IDLE, CALC, DONE; in_valid outside LOAD ignored.
REQ-020 Term set: main term k = prod over r of m[r][(r+k) mod n]; secondary term k = prod over r of m[r][(n-1-k-r) mod n].
REQ-021 Term count: n>=3 -> main k=0..n-1 then secondary k=0..n-1; n=2 -> main k=0, secondary k=0; n=1 -> main k=0 only.
REQ-022 CALC: each term takes exactly n cycles, row r=0..n-1 one per cycle; r=0 loads partial=element; r>0 partial=partial*element (low 16 bits).
REQ-023 On each term's final row cycle, accumulator SHALL add (main) or subtract (secondary) the completed product, modulo 2^16.
REQ-024 CALC duration SHALL be (term count)*n cycles: n=1:1, n=2:4, n=3:18, n=4:32, n=5:50; then DONE.
REQ-025 Result SHALL be bit-exact with the combinational determinant datapath (sum over k of main_k - secondary_k, 16-bit wrap).
REQ-026 DONE: det_valid=1, determinant=accumulator, held stable until det_ready; on handshake go IDLE next cycle, determinant retains last value.
REQ-027 det_valid&det_ready and start in same cycle: start ignored (state is DONE).
REQ-028 Stalled in_valid in LOAD SHALL hold state indefinitely with no timeout.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, in_ready=0, det_valid=0, busy=0, err=0, determinant=0x0000, counters/accumulator=0.
REQ-030 Reset mid-LOAD or mid-CALC SHALL abort the operation; after release, next valid start begins fresh with no residual elements.
REQ-031 Outputs SHALL be at reset values in the first cycle after rst_n rises, until a start is taken.

Verification
REQ-032 n=2, stream 3,5,2,7, det_ready=1 -> 4 CALC cycles, det_valid with determinant=0x000B (21-10).
REQ-033 n=2, stream 1,2,3,4 -> determinant=0xFFFE (4-6 wrapped).
REQ-034 n=3, stream 2,0,1,1,3,2,1,1,1 -> 18 CALC cycles, determinant=0x0000 (main 7, secondary 7).
REQ-035 n=1, stream 200 -> 1 CALC cycle, determinant=0x00C8; n=5 all elements 255 -> matches combinational datapath, 50 CALC cycles.
REQ-036 start with size=6 -> err pulse one cycle, busy stays 0, in_ready stays 0; start with size=0 -> same.
REQ-037 rst_n low after 3 elements of n=3 load -> all outputs reset immediately; new start n=2 stream 3,5,2,7 -> 0x000B; det_ready held low 10 cycles -> det_valid and determinant stable throughout.
